instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Initiator side of the processor's run/Din/done handshake.
- Walks a program counter over a range of ROM addresses.
- For each address: presents it on Din, pulses run, then waits for the processor's done before advancing.
- Sits between top-level control (start/stop) and the processor core; replaces manual run/Din stimulus.

Parameters:
- ADDR_W, 5, width of Din / program counter (ROM address).
- CNT_W, 8, width of the completed-instruction counter.
- TIMEOUT, 16, max WAIT cycles for done before flagging error (must be ≥2).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin sequence; sampled only in IDLE or ERROR.
- stop  input  1  request halt after the current instruction completes.
- start_addr  input  ADDR_W  first ROM address, latched on start.
- end_addr  input  ADDR_W  last ROM address, latched on start.
- done  input  1  from processor: instruction finished.
- Din  output  ADDR_W  ROM address to processor, equals the PC register.
- run  output  1  one-cycle pulse launching the instruction at Din.
- busy  output  1  high in ISSUE and WAIT.
- seq_done  output  1  one-cycle pulse when the sequence ends normally.
- error  output  1  done timeout occurred; sticky until start or reset.
- instr_count  output  CNT_W  instructions completed since last start; saturates at all-ones.

Behaviour:
- Reset (async, immediate, including mid-instruction):
  - State goes to IDLE.
  - Din, instr_count, wait counter, end register and stop_pending cleared.
  - run, busy, seq_done and error all 0.
- IDLE:
  - start=1 → latch pc←start_addr, end←end_addr; clear instr_count, error and stop_pending; go to ISSUE.
  - stop is ignored; done is ignored.
- ISSUE (exactly 1 cycle):
  - run=1, busy=1, Din=pc.
  - Clear wait counter; go to WAIT.
  - done seen in this cycle is ignored (treated as stale).
- WAIT:
  - run=0, busy=1, Din held stable.
  - stop=1 in any cycle sets stop_pending; the current instruction is never aborted.
  - done=1:
    - instr_count += 1, saturating.
    - If pc==end or stop_pending → IDLE with a seq_done pulse next cycle.
    - Else pc←pc+1 (mod 2^ADDR_W) and go to ISSUE.
  - done=0: wait counter += 1. When it reaches TIMEOUT → ERROR.
- ERROR:
  - error=1, busy=0, run=0; Din holds the faulting address.
  - start=1 → same as start from IDLE (error clears).
- Latency and throughput:
  - start→run: 1 cycle.
  - done→next run: 1 cycle.
  - Per instruction: 1 ISSUE cycle plus N WAIT cycles, where done arrives on WAIT cycle N.
- Wrap-around: if start_addr > end_addr, the PC wraps from 2^ADDR_W−1 to 0 and continues until it reaches end.
- start_addr == end_addr: exactly one instruction is executed.
- Input timing: start and stop asserted together in IDLE → start wins; stop is not latched.
- seq_done and error are never asserted in the same cycle.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined:
  - pc==end with done and no stop_pending → pc←start register (latched at start), then ISSUE.
  - The sequence repeats until stop is seen; that iteration's completion gives seq_done.
  - instr_count keeps accumulating and saturates.
- Not defined: the sequence ends at end_addr as described above; no start register is kept.

Test Plan:
- Single instruction: start_addr=3, end_addr=3, done 3 cycles after run → one run pulse with Din=3; seq_done 1 cycle after done; instr_count=1.
- Range: 0..4, done 2 cycles after each run → Din runs 0,1,2,3,4; five run pulses, each 1 cycle wide; instr_count=5; busy low after seq_done.
- Wrap: start_addr=30, end_addr=1 → Din sequence 30,31,0,1; instr_count=4.
- Stop mid-sequence: range 0..9, stop pulsed during WAIT of address 2 → address 2 still completes; no run for address 3; seq_done pulses; instr_count=3.
- Timeout: done held 0 after run at address 5, TIMEOUT=16 → error=1 after 16 WAIT cycles; Din=5; busy=0. A new start clears error.
- Reset mid-WAIT: assert reset asynchronously → run, busy, Din, error and instr_count all 0 immediately. With SEQ_LOOP_EN defined, range 2..3 repeats 2,3,2,3 until stop.

Source files
------------

// File: rtl/instr_sequencer.sv
// Run/Din/done initiator: walks a PC over a ROM address range.
// Define SEQ_LOOP_EN to repeat the range until stop is requested.
module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              done,
  output logic [ADDR_W-1:0] Din,
  output logic              run,
  output logic              busy,
  output logic              seq_done,
  output logic              error,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] TO = WC_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              stop_q, stop_d;
  logic              sdone_q, sdone_d;
`ifdef SEQ_LOOP_EN
  logic [ADDR_W-1:0] beg_q, beg_d;
`endif

  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign Din         = pc_q;
  assign run         = (state_q == S_ISSUE);
  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign error       = (state_q == S_ERROR);
  assign seq_done    = sdone_q;
  assign instr_count = cnt_q;

  // Next-state: launch, wait for done, advance or finish, timeout.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    end_d   = end_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    sdone_d = 1'b0;
`ifdef SEQ_LOOP_EN
    beg_d   = beg_q;
`endif
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          pc_d    = start_addr;
          end_d   = end_addr;
          cnt_d   = '0;
          stop_d  = 1'b0;
          wcnt_d  = '0;
          state_d = S_ISSUE;
`ifdef SEQ_LOOP_EN
          beg_d   = start_addr;
`endif
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stop) stop_d = 1'b1;
        if (done) begin
          cnt_d = cnt_inc;
          if (stop_q || stop) begin
            state_d = S_IDLE;
            sdone_d = 1'b1;
          end else if (pc_q == end_q) begin
`ifdef SEQ_LOOP_EN
            pc_d    = beg_q;
            state_d = S_ISSUE;
`else
            state_d = S_IDLE;
            sdone_d = 1'b1;
`endif
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_d == TO) state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared immediately on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      end_q   <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      sdone_q <= 1'b0;
`ifdef SEQ_LOOP_EN
      beg_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      end_q   <= end_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      sdone_q <= sdone_d;
`ifdef SEQ_LOOP_EN
      beg_q   <= beg_d;
`endif
    end
  end

endmodule
